// File: rtl/conv_pkg.sv
// Shared constants for the convolution MAC array: default geometry and
// widths, the controller state encoding, and the weight-port address map.
package conv_pkg;

    localparam int CONV_KERNEL_SIZE   = 5;
    localparam int CONV_NUM_CH        = 3;
    localparam int CONV_DATA_W        = 8;
    localparam int CONV_WEIGHT_W      = 8;
    localparam int CONV_ACC_W         = 20;
    localparam int CONV_CONV_PER_LINE = 24;

    // Controller states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] BIAS  = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    // Biases sit directly above the weight block in the register map.
    function automatic int bias_base(input int num_ch, input int kernel_size);
        return num_ch * kernel_size * kernel_size;
    endfunction

endpackage

// File: rtl/conv_row_dot.sv
// Combinational dot product of one kernel row for one output channel.
// Pixels are unsigned and zero-extended; weights are signed. The sum is
// returned at accumulator width and wraps modulo 2^ACC_W.
module conv_row_dot
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = CONV_KERNEL_SIZE,
    parameter int DATA_W      = CONV_DATA_W,
    parameter int WEIGHT_W    = CONV_WEIGHT_W,
    parameter int ACC_W       = CONV_ACC_W
) (
    input  logic [KERNEL_SIZE*DATA_W-1:0]   pix_row,
    input  logic [KERNEL_SIZE*WEIGHT_W-1:0] wt_row,
    output logic signed [ACC_W-1:0]         dot
);

    localparam int PROD_W = DATA_W + WEIGHT_W + 1;

    logic signed [PROD_W-1:0] prod;

    // Sum of KERNEL_SIZE signed pixel*weight products
    always_comb begin
        dot  = '0;
        prod = '0;
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            prod = $signed({1'b0, pix_row[k*DATA_W +: DATA_W]})
                 * $signed(wt_row[k*WEIGHT_W +: WEIGHT_W]);
            dot  = dot + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

endmodule

// File: rtl/conv_mac_array.sv
// Convolution MAC array: accepts one KERNEL_SIZE x KERNEL_SIZE window,
// accumulates one kernel row per cycle for NUM_CH channels, adds a bias and
// presents the result to the pooling stage with a valid/ready handshake.
// Weights and biases are written through a small register port while idle.
// Optional build macro: CONV_MAC_RELU_EN clamps negative channel results to 0.
module conv_mac_array
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE   = CONV_KERNEL_SIZE,
    parameter int NUM_CH        = CONV_NUM_CH,
    parameter int DATA_W        = CONV_DATA_W,
    parameter int WEIGHT_W      = CONV_WEIGHT_W,
    parameter int ACC_W         = CONV_ACC_W,
    parameter int CONV_PER_LINE = CONV_CONV_PER_LINE
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_W-1:0]              window_data,
    input  logic                                                   valid_win_MAC,
    output logic                                                   ready_MAC,
    input  logic                                                   wt_we,
    input  logic [$clog2(NUM_CH*(KERNEL_SIZE*KERNEL_SIZE+1))-1:0]  wt_addr,
    input  logic [WEIGHT_W-1:0]                                    wt_data,
    output logic [NUM_CH*ACC_W-1:0]                                conv_out,
    output logic                                                   valid_out,
    input  logic                                                   ready_pool,
    output logic                                                   line_done
);

    localparam int KK        = KERNEL_SIZE * KERNEL_SIZE;
    localparam int NUM_WT    = NUM_CH * KK;
    localparam int BIAS_BASE = bias_base(NUM_CH, KERNEL_SIZE);
    localparam int ADDR_W    = $clog2(NUM_CH * (KK + 1));
    localparam int ROW_W     = $clog2(KERNEL_SIZE);
    localparam int CNT_W     = $clog2(CONV_PER_LINE);

    logic [1:0]                 state;
    logic [ROW_W-1:0]           row_cnt;
    logic [CNT_W-1:0]           conv_cnt;
    logic [KK*DATA_W-1:0]       win;
    logic signed [WEIGHT_W-1:0] wts  [NUM_WT];
    logic signed [WEIGHT_W-1:0] bias [NUM_CH];
    logic signed [ACC_W-1:0]    acc  [NUM_CH];
    logic signed [ACC_W-1:0]    dot  [NUM_CH];

    logic [KERNEL_SIZE*DATA_W-1:0]                pix_row;
    logic [NUM_CH-1:0][KERNEL_SIZE*WEIGHT_W-1:0]  wt_row;

    logic accept;
    logic handshake;
    logic last_row;

    // Bias add and optional ReLU applied when the final result is formed.
    function automatic logic signed [ACC_W-1:0] finish_ch(
        input logic signed [ACC_W-1:0]    a,
        input logic signed [WEIGHT_W-1:0] b
    );
        logic signed [ACC_W-1:0] s;
        s = a + {{(ACC_W-WEIGHT_W){b[WEIGHT_W-1]}}, b};
`ifdef CONV_MAC_RELU_EN
        if (s[ACC_W-1]) begin
            s = '0;
        end
`endif
        return s;
    endfunction

    // A pending weight write blocks window acceptance, so the write wins.
    assign ready_MAC = (state == IDLE) && !wt_we && !rst;
    assign accept    = valid_win_MAC && ready_MAC;
    assign handshake = valid_out && ready_pool;
    assign last_row  = (row_cnt == ROW_W'(KERNEL_SIZE - 1));
    assign line_done = handshake && (conv_cnt == CNT_W'(CONV_PER_LINE - 1));

    // Select the current kernel row of pixels and per-channel weights
    always_comb begin
        pix_row = '0;
        wt_row  = '0;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            if (row_cnt == ROW_W'(r)) begin
                pix_row = win[r*KERNEL_SIZE*DATA_W +: KERNEL_SIZE*DATA_W];
                for (int c = 0; c < NUM_CH; c++) begin
                    for (int k = 0; k < KERNEL_SIZE; k++) begin
                        wt_row[c][k*WEIGHT_W +: WEIGHT_W] = wts[c*KK + r*KERNEL_SIZE + k];
                    end
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            conv_row_dot #(
                .KERNEL_SIZE (KERNEL_SIZE),
                .DATA_W      (DATA_W),
                .WEIGHT_W    (WEIGHT_W),
                .ACC_W       (ACC_W)
            ) u_dot (
                .pix_row (pix_row),
                .wt_row  (wt_row[g]),
                .dot     (dot[g])
            );
        end
    endgenerate

    // Weight/bias register file; writes land only while idle, others dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WT; i++) begin
                wts[i] <= '0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                bias[c] <= '0;
            end
        end else if ((state == IDLE) && wt_we) begin
            for (int i = 0; i < NUM_WT; i++) begin
                if (wt_addr == ADDR_W'(i)) begin
                    wts[i] <= wt_data;
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (wt_addr == ADDR_W'(BIAS_BASE + c)) begin
                    bias[c] <= wt_data;
                end
            end
        end
    end

    // Controller plus accumulate / bias / output datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row_cnt   <= '0;
            conv_cnt  <= '0;
            valid_out <= 1'b0;
            conv_out  <= '0;
            win       <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        win     <= window_data;
                        row_cnt <= '0;
                        state   <= ACCUM;
                        for (int c = 0; c < NUM_CH; c++) begin
                            acc[c] <= '0;
                        end
                    end
                end
                ACCUM: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        acc[c] <= acc[c] + dot[c];
                    end
                    if (last_row) begin
                        row_cnt <= '0;
                        state   <= BIAS;
                    end else begin
                        row_cnt <= row_cnt + ROW_W'(1);
                    end
                end
                BIAS: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        conv_out[c*ACC_W +: ACC_W] <= finish_ch(acc[c], bias[c]);
                    end
                    valid_out <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (handshake) begin
                        valid_out <= 1'b0;
                        state     <= IDLE;
                        if (conv_cnt == CNT_W'(CONV_PER_LINE - 1)) begin
                            conv_cnt <= '0;
                        end else begin
                            conv_cnt <= conv_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_array.sv
// Self-checking bench for conv_mac_array: directed steps with random data,
// compared against a plain-arithmetic model of the convolution.
module tb_conv_mac_array;

    localparam int K      = 5;
    localparam int NC     = 3;
    localparam int DW     = 8;
    localparam int WW     = 8;
    localparam int AW     = 20;
    localparam int CPL    = 24;
    localparam int KK     = K * K;
    localparam int ADDR_W = $clog2(NC * (KK + 1));

    logic                 clk = 1'b0;
    logic                 rst;
    logic [KK*DW-1:0]     window_data;
    logic                 valid_win_MAC;
    logic                 ready_MAC;
    logic                 wt_we;
    logic [ADDR_W-1:0]    wt_addr;
    logic [WW-1:0]        wt_data;
    logic [NC*AW-1:0]     conv_out;
    logic                 valid_out;
    logic                 ready_pool;
    logic                 line_done;

    int n_assert = 0;
    int n_fail   = 0;
    int wm [NC*KK];
    int bm [NC];
    int pix [KK];
    int hs_count;
    int pulses;
    logic [NC*AW-1:0] held;

    always #5 clk = ~clk;

    conv_mac_array #(
        .KERNEL_SIZE   (K),
        .NUM_CH        (NC),
        .DATA_W        (DW),
        .WEIGHT_W      (WW),
        .ACC_W         (AW),
        .CONV_PER_LINE (CPL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .window_data   (window_data),
        .valid_win_MAC (valid_win_MAC),
        .ready_MAC     (ready_MAC),
        .wt_we         (wt_we),
        .wt_addr       (wt_addr),
        .wt_data       (wt_data),
        .conv_out      (conv_out),
        .valid_out     (valid_out),
        .ready_pool    (ready_pool),
        .line_done     (line_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int to_s8(input int v);
        int x;
        x = v & 255;
        return (x > 127) ? x - 256 : x;
    endfunction

    // Reference: dot product of window and channel weights, plus bias, wrapped.
    function automatic logic [AW-1:0] model_ch(input int c);
        longint      s;
        logic [63:0] sv;
        logic [AW-1:0] r;
        s = longint'(bm[c]);
        for (int i = 0; i < KK; i++) begin
            s += longint'(pix[i]) * longint'(wm[c*KK + i]);
        end
        sv = s;
        r  = sv[AW-1:0];
`ifdef CONV_MAC_RELU_EN
        if (r[AW-1]) r = '0;
`endif
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NC*KK; i++) wm[i] = 0;
        for (int c = 0; c < NC; c++) bm[c] = 0;
    endtask

    task automatic write_wt(input int addr, input int val, input bit take);
        wt_addr = ADDR_W'(addr);
        wt_data = WW'(val);
        wt_we   = 1'b1;
        @(posedge clk);
        #1;
        wt_we   = 1'b0;
        if (take) begin
            if (addr < NC*KK) wm[addr] = to_s8(val);
            else if (addr < NC*KK + NC) bm[addr - NC*KK] = to_s8(val);
        end
    endtask

    task automatic random_pixels();
        for (int i = 0; i < KK; i++) pix[i] = int'($urandom_range(0, 255));
    endtask

    task automatic accept_window();
        int waited;
        for (int i = 0; i < KK; i++) window_data[i*DW +: DW] = DW'(pix[i]);
        valid_win_MAC = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!ready_MAC && waited < 50);
        if (!ready_MAC) check("accept_timeout", 64'(ready_MAC), 64'd1);
        @(posedge clk);
        #1;
        valid_win_MAC = 1'b0;
    endtask

    task automatic wait_output(input int consumed);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_out && n < 20);
        check("latency_edges", 64'(n - 1 + consumed), 64'(K + 1));
    endtask

    task automatic check_outputs(input string tag);
        for (int c = 0; c < NC; c++) begin
            check($sformatf("%s_ch%0d", tag, c), 64'(conv_out[c*AW +: AW]), 64'(model_ch(c)));
        end
    endtask

    task automatic handshake();
        bit exp_ld;
        #1;
        exp_ld = ((hs_count % CPL) == CPL - 1);
        check($sformatf("line_done_hs%0d", hs_count), 64'(line_done), 64'(exp_ld));
        if (line_done) pulses++;
        @(posedge clk);
        #1;
        hs_count++;
        check("valid_drop", 64'(valid_out), 64'd0);
    endtask

    task automatic run_window(input string tag);
        accept_window();
        wait_output(0);
        check_outputs(tag);
        handshake();
    endtask

    initial begin
        rst = 1'b1; valid_win_MAC = 1'b0; wt_we = 1'b0; wt_addr = '0;
        wt_data = '0; window_data = '0; ready_pool = 1'b1;
        hs_count = 0; pulses = 0; held = '0;
        model_clear();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready_mac", 64'(ready_MAC), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_conv_out", 64'(conv_out), 64'd0);
        check("rst_line_done", 64'(line_done), 64'd0);
        check("rst_ready_after", 64'(ready_MAC), 64'd1);
        @(posedge clk);
        #1;

        // Weights c+1, bias 0, pixels 0x10+i
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < KK; i++) write_wt(c*KK + i, c + 1, 1'b1);
        for (int i = 0; i < KK; i++) pix[i] = 16 + i;
        accept_window();
        wait_output(0);
        check_outputs("base");
        check("base_ch0_const", 64'(conv_out[0 +: AW]), 64'd700);
        check("base_ch1_const", 64'(conv_out[AW +: AW]), 64'd1400);
        check("base_ch2_const", 64'(conv_out[2*AW +: AW]), 64'd2100);
        handshake();

        // Bias ch0 = -4
        write_wt(NC*KK, 8'hFC, 1'b1);
        accept_window();
        wait_output(0);
        check_outputs("bias");
        check("bias_ch0_const", 64'(conv_out[0 +: AW]), 64'd696);
        handshake();

        // Downstream stall for 10 cycles
        ready_pool = 1'b0;
        accept_window();
        wait_output(0);
        check_outputs("stall");
        held = conv_out;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(valid_out), 64'd1);
            check("stall_hold", 64'(conv_out), 64'(held));
            check("stall_ready_mac", 64'(ready_MAC), 64'd0);
            check("stall_line_done", 64'(line_done), 64'd0);
        end
        ready_pool = 1'b1;
        handshake();

        // Random weights/biases, a run of back-to-back windows across a line end
        for (int i = 0; i < NC*(KK+1); i++) write_wt(i, int'($urandom_range(0, 255)), 1'b1);
        pulses = 0;
        for (int w = 0; w < CPL + 1; w++) begin
            random_pixels();
            run_window("line");
        end
        check("line_pulses", 64'(pulses), 64'd1);

        // Negative result: ch0 weights all -1, bias 0
        for (int i = 0; i < KK; i++) write_wt(i, 8'hFF, 1'b1);
        write_wt(NC*KK, 0, 1'b1);
        for (int i = 0; i < KK; i++) pix[i] = 16 + i;
        accept_window();
        wait_output(0);
        check_outputs("neg");
`ifdef CONV_MAC_RELU_EN
        check("neg_ch0_const", 64'(conv_out[0 +: AW]), 64'd0);
`else
        check("neg_ch0_const", 64'(conv_out[0 +: AW]), 64'hFFD44);
`endif
        handshake();

        // Write and window in the same idle cycle: write wins, no acceptance
        random_pixels();
        for (int i = 0; i < KK; i++) window_data[i*DW +: DW] = DW'(pix[i]);
        wt_addr = ADDR_W'(0); wt_data = WW'(7); wt_we = 1'b1; valid_win_MAC = 1'b1;
        @(negedge clk);
        check("collide_ready_mac", 64'(ready_MAC), 64'd0);
        @(posedge clk);
        #1;
        wt_we = 1'b0; valid_win_MAC = 1'b0;
        wm[0] = 7;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("collide_no_accept", 64'(valid_out), 64'd0);
        end
        @(posedge clk);
        #1;
        run_window("after_collide");

        // Write during ACCUM is dropped
        random_pixels();
        accept_window();
        write_wt(1, 8'h55, 1'b0);
        wait_output(1);
        check_outputs("accum_write");
        handshake();

        // Out-of-range address is ignored
        write_wt(100, 8'h33, 1'b1);
        random_pixels();
        run_window("oor");

        // Reset in the middle of ACCUM
        random_pixels();
        accept_window();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_ready_mac", 64'(ready_MAC), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_valid_out", 64'(valid_out), 64'd0);
        check("midrst_ready_after", 64'(ready_MAC), 64'd1);
        check("midrst_conv_out", 64'(conv_out), 64'd0);
        model_clear();
        hs_count = 0;
        @(posedge clk);
        #1;
        random_pixels();
        run_window("cleared");

        // Line counter restarts from zero after reset
        for (int i = 0; i < NC*(KK+1); i++) write_wt(i, int'($urandom_range(0, 255)), 1'b1);
        pulses = 0;
        for (int w = 0; w < CPL - 1; w++) begin
            random_pixels();
            run_window("line2");
        end
        check("line2_pulses", 64'(pulses), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
